uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
UART receiver for the host-to-FPGA direction; the counterpart of the existing FIFO-fed UART transmit path.
- Samples the host serial line, deserialises 8N1 frames (LSB first) and pushes each good byte into an internal show-ahead FIFO.
- Consumers drain the FIFO with the same next/have_next handshake that the transmit-side FIFO uses.
- Sits between the board pin and a CSR-readable data/status interface.

Parameters:
FIFO_DEPTH, 8, byte entries in receive FIFO; power of two, >=2
SYNC_STAGES, 2, flops in rx input synchronizer; >=2

Ports:
clk_i  input  1  system clock (clk_wiz output)
reset_i  input  1  reset, active-low, synchronous
rx_i  input  1  asynchronous serial line from host, idle high
baud_div_i  input  32  bit period minus one, in clk_i cycles; must be >=3 and stable while not idle
next_i  input  1  pop head byte when have_next_o=1
clr_err_i  input  1  clears sticky error flags
data_o  output  8  head byte of FIFO (show-ahead), valid when have_next_o=1
have_next_o  output  1  FIFO not empty
count_o  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy
frame_err_o  output  1  sticky: stop bit sampled 0
overrun_o  output  1  sticky: byte dropped, FIFO full
parity_err_o  output  1  sticky parity error (see Optional Feature)
busy_o  output  1  receiver FSM not in IDLE

Behaviour:
- Reset (reset_i=0 at clk_i edge): FSM=IDLE, synchronizer flops=1, counters=0, FIFO empty; data_o=0, have_next_o=0, count_o=0, all error flags=0, busy_o=0. Reset mid-frame abandons the partial byte; FIFO contents are lost.
- rx_i passes through SYNC_STAGES flops -> rx_s (latency SYNC_STAGES cycles). All sampling uses rx_s.
- 32-bit cycle counter cnt; bit index 0..7.
- FSM:
  - IDLE: rx_s=0 -> START, cnt=0.
  - START: cnt increments. At cnt==baud_div_i>>1, sample rx_s:
    - 1 -> false start, IDLE.
    - 0 -> DATA, cnt=0, bit=0.
  - DATA: at cnt==baud_div_i, shift rx_s into bit[bit] (LSB first) and set cnt=0. After bit 7 -> STOP (or PARITY with macro).
  - STOP: at cnt==baud_div_i, sample rx_s:
    - 1 -> push byte, IDLE.
    - 0 -> frame_err_o=1, discard byte, BREAK.
  - BREAK: wait for rx_s=1, then IDLE. No start detection while in BREAK.
- busy_o=1 in every state except IDLE.
- Push timing: byte is written on the stop-sample cycle. have_next_o/data_o reflect it the next cycle.
- FIFO:
  - Circular buffer, pointer wrap at FIFO_DEPTH.
  - Pop occurs when next_i=1 and have_next_o=1. next_i while empty is ignored.
  - Push when full and no pop in the same cycle -> byte dropped, overrun_o=1, contents unchanged.
  - Push and pop in the same cycle while full -> both succeed, count unchanged, no overrun.
  - Push and pop in the same cycle while count==1 -> data_o shows the new byte next cycle.
  - Push into an empty FIFO with next_i=1 -> push only; there is nothing to pop.
- Sticky flags clear on clr_err_i=1. If set and clear happen in the same cycle, set wins.
- baud_div_i changed mid-frame: undefined frame result; FSM must still return to IDLE.

Optional Feature:
UART_RX_PARITY_EN
- Defined: a PARITY state follows DATA. Even parity bit is sampled at cnt==baud_div_i. On mismatch, parity_err_o=1, the stop bit is still checked, and the byte is discarded. Frame = 8E1.
- Undefined: no PARITY state, parity_err_o tied 0, frame = 8N1.

Test Plan:
1. baud_div_i=15, host sends 0x42 8N1 -> have_next_o=1 one cycle after stop sample, data_o=0x42, count_o=1; next_i pulse -> have_next_o=0, count_o=0.
2. baud_div_i=15, rx_i low for 4 cycles then high (glitch) -> FSM returns to IDLE, have_next_o stays 0, no error flag.
3. Send 0xA5 with stop bit 0, hold low 40 cycles, then idle, then send 0x11 -> frame_err_o=1, 0xA5 absent; 0x11 received. clr_err_i -> frame_err_o=0.
4. FIFO_DEPTH=8: send 0x00..0x08 with no pops -> count_o=8, overrun_o=1; eight pops return 0x00..0x07 in order.
5. FIFO full, assert next_i on the stop-sample cycle of byte 0x77 -> count_o stays 8, overrun_o=0, last entry 0x77. Second case: reset_i=0 during DATA bit 4 -> all outputs at reset values; following 0x3C received correctly.
6. With UART_RX_PARITY_EN: 0x03 with parity 0 -> accepted; 0x03 with parity 1 -> parity_err_o=1, FIFO empty.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, LSB first) feeding a show-ahead byte FIFO with sticky error flags.
// Define UART_RX_PARITY_EN to receive 8E1 frames and drive parity_err_o.
module uart_rx_fifo #(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          rx_i,
  input  logic [31:0]                   baud_div_i,
  input  logic                          next_i,
  input  logic                          clr_err_i,
  output logic [7:0]                    data_o,
  output logic                          have_next_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o,
  output logic                          frame_err_o,
  output logic                          overrun_o,
  output logic                          parity_err_o,
  output logic                          busy_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DepthCnt = FIFO_DEPTH[AW:0];

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StBreak} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [31:0]            cnt_q, cnt_d;
  logic [2:0]             bit_q, bit_d;
  logic [7:0]             shift_q, shift_d;
  logic                   par_bad_q, par_bad_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_q, overrun_d;
  logic [AW-1:0]          wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]            count_q, count_d;
  logic [7:0]             mem_q [FIFO_DEPTH];
  logic [7:0]             mem_d [FIFO_DEPTH];

  logic        rx_s;
  logic [31:0] half_div;
  logic        push_req, frame_set, pop, full, push_ok, ovr_set;

  assign rx_s     = sync_q[SYNC_STAGES-1];
  assign sync_d   = {sync_q[SYNC_STAGES-2:0], rx_i};
  assign half_div = {1'b0, baud_div_i[31:1]};

`ifdef UART_RX_PARITY_EN
  logic par_set;
  logic par_err_q, par_err_d;
  assign par_err_d    = par_set | (par_err_q & ~clr_err_i);
  assign parity_err_o = par_err_q;
`else
  assign parity_err_o = 1'b0;
`endif

  // Counter compares use >= so a baud change mid-frame still terminates the bit.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_bad_d = par_bad_q;
    push_req  = 1'b0;
    frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_set   = 1'b0;
`endif
    case (state_q)
      StIdle: begin
        cnt_d     = '0;
        par_bad_d = 1'b0;
        if (!rx_s) state_d = StStart;
      end
      StStart: begin
        if (cnt_q >= half_div) begin
          if (rx_s) begin
            state_d = StIdle;
          end else begin
            state_d = StData;
            cnt_d   = '0;
            bit_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StData: begin
        if (cnt_q >= baud_div_i) begin
          shift_d = {rx_s, shift_q[7:1]};
          cnt_d   = '0;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (cnt_q >= baud_div_i) begin
          cnt_d     = '0;
          par_bad_d = rx_s ^ (^shift_q);
          par_set   = rx_s ^ (^shift_q);
          state_d   = StStop;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
`endif
      StStop: begin
        if (cnt_q >= baud_div_i) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d  = StIdle;
            push_req = ~par_bad_q;
          end else begin
            frame_set = 1'b1;
            state_d   = StBreak;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StBreak: begin
        if (rx_s) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FIFO: a pop frees the slot the same-cycle push needs when full.
  always_comb begin
    pop     = next_i & (count_q != '0);
    full    = (count_q == DepthCnt);
    push_ok = push_req & (~full | pop);
    ovr_set = push_req & full & ~pop;
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_ok) begin
      mem_d[wptr_q] = shift_q;
      wptr_d        = wptr_q + 1'b1;
    end
    if (pop) rptr_d = rptr_q + 1'b1;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    frame_err_d = frame_set | (frame_err_q & ~clr_err_i);
    overrun_d   = ovr_set | (overrun_q & ~clr_err_i);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q     <= StIdle;
      sync_q      <= '1;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      par_bad_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
`ifdef UART_RX_PARITY_EN
      par_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      par_bad_q   <= par_bad_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
`ifdef UART_RX_PARITY_EN
      par_err_q   <= par_err_d;
`endif
    end
  end

  // Storage needs no reset: data_o is gated by occupancy.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign have_next_o = (count_q != '0);
  assign data_o      = have_next_o ? mem_q[rptr_q] : 8'h00;
  assign count_o     = count_q;
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;
  assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomised bench for uart_rx_fifo against a queue-based model of frames, FIFO and flags.
// Build with UART_RX_PARITY_EN defined to exercise 8E1 framing.
module tb_uart_rx_fifo;

  localparam int Depth = 8;
  localparam int Sync  = 2;
`ifdef UART_RX_PARITY_EN
  localparam bit ParEn = 1'b1;
`else
  localparam bit ParEn = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        reset_i, rx_i, next_i, clr_err_i;
  logic [31:0] baud_div_i;
  logic [7:0]  data_o;
  logic        have_next_o, frame_err_o, overrun_o, parity_err_o, busy_o;
  logic [3:0]  count_o;

  uart_rx_fifo #(.FIFO_DEPTH(Depth), .SYNC_STAGES(Sync)) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .rx_i         (rx_i),
    .baud_div_i   (baud_div_i),
    .next_i       (next_i),
    .clr_err_i    (clr_err_i),
    .data_o       (data_o),
    .have_next_o  (have_next_o),
    .count_o      (count_o),
    .frame_err_o  (frame_err_o),
    .overrun_o    (overrun_o),
    .parity_err_o (parity_err_o),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int         n_chk = 0;
  int         n_err = 0;
  logic [7:0] q[$];
  bit         frm_m, ovr_m, par_m;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_data"}, data_o, 0);
    check_eq({tag, "_have"}, have_next_o, 0);
    check_eq({tag, "_count"}, count_o, 0);
    check_eq({tag, "_frm"}, frame_err_o, 0);
    check_eq({tag, "_ovr"}, overrun_o, 0);
    check_eq({tag, "_par"}, parity_err_o, 0);
    check_eq({tag, "_busy"}, busy_o, 0);
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, "_count"}, count_o, q.size());
    check_eq({tag, "_have"}, have_next_o, q.size() > 0);
    if (q.size() > 0) check_eq({tag, "_data"}, data_o, q[0]);
    check_eq({tag, "_frm"}, frame_err_o, frm_m);
    check_eq({tag, "_ovr"}, overrun_o, ovr_m);
    check_eq({tag, "_par"}, parity_err_o, par_m);
    check_eq({tag, "_busy"}, busy_o, 0);
  endtask

  task automatic pop_one(input string tag);
    logic [7:0] h;
    if (q.size() > 0) begin
      h = q.pop_front();
      check_eq({tag, "_pop"}, data_o, h);
    end
    next_i = 1'b1;
    tick();
    next_i = 1'b0;
  endtask

  task automatic clear_err();
    clr_err_i = 1'b1;
    tick();
    clr_err_i = 1'b0;
    frm_m = 0; ovr_m = 0; par_m = 0;
  endtask

  // Drives one whole frame plus idle gap; line is sampled mid-bit after Sync+1 cycles of latency.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit par_flip,
                            input bit pop_at_stop);
    int          per, nbits, stop_edge, total, pre, post;
    logic [10:0] bits;
    logic [7:0]  dropped;
    per   = int'(baud_div_i) + 1;
    nbits = ParEn ? 11 : 10;
    bits  = {stop_ok, stop_ok, b, 1'b0};
    if (ParEn) bits[9] = (^b) ^ par_flip;
    stop_edge = Sync + 2 + int'(baud_div_i >> 1) + (nbits - 1) * per;
    pre = q.size();
    if (pop_at_stop && q.size() > 0) dropped = q.pop_front();
    if (ParEn && par_flip) par_m = 1;
    if (!stop_ok) frm_m = 1;
    else if (!(ParEn && par_flip)) begin
      if (q.size() < Depth) q.push_back(b);
      else ovr_m = 1;
    end
    post  = q.size();
    total = nbits * per + int'(baud_div_i) + 8;
    for (int c = 0; c < total; c++) begin
      tick();
      rx_i   = (c / per < nbits) ? bits[c / per] : stop_ok;
      next_i = pop_at_stop && (c == stop_edge - 1);
      if (c == stop_edge - 1) check_eq("cnt_pre_stop", count_o, pre);
      if (c == stop_edge) check_eq("cnt_post_stop", count_o, post);
    end
    next_i = 1'b0;
    if (!stop_ok) begin
      repeat (40) tick();
      rx_i = 1'b1;
      repeat (Sync + 4) tick();
    end
  endtask

  initial begin
    logic [7:0] b;
    reset_i = 1'b0; rx_i = 1'b1; next_i = 1'b0; clr_err_i = 1'b0; baud_div_i = 32'd15;
    frm_m = 0; ovr_m = 0; par_m = 0;
    repeat (3) tick();
    check_reset("reset");
    reset_i = 1'b1;
    tick();

    send_frame(8'h42, 1, 0, 0);
    check_state("t1");
    pop_one("t1");
    check_state("t1_empty");

    rx_i = 1'b0;
    repeat (4) tick();
    rx_i = 1'b1;
    repeat (25) tick();
    check_state("glitch");

    send_frame(8'hA5, 0, 0, 0);
    send_frame(8'h11, 1, 0, 0);
    check_state("t3");
    clear_err();
    check_state("t3_clr");
    pop_one("t3");

    for (int i = 0; i <= 8; i++) send_frame(8'(i), 1, 0, 0);
    check_state("t4_full");
    for (int i = 0; i < 8; i++) pop_one("t4");
    check_state("t4_empty");
    clear_err();

    for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i), 1, 0, 0);
    send_frame(8'h77, 1, 0, 1);
    check_state("t5_pop_push");
    for (int i = 0; i < 8; i++) pop_one("t5");

    send_frame(8'h99, 1, 0, 0);
    b = 8'h5A;
    for (int c = 0; c < 88; c++) begin
      tick();
      rx_i = (c < 16) ? 1'b0 : b[c / 16 - 1];
    end
    reset_i = 1'b0;
    rx_i    = 1'b1;
    repeat (3) tick();
    check_reset("midreset");
    reset_i = 1'b1;
    q.delete();
    frm_m = 0; ovr_m = 0; par_m = 0;
    tick();
    send_frame(8'h3C, 1, 0, 0);
    check_state("t5_after_reset");
    pop_one("t5b");

    if (ParEn) begin
      send_frame(8'h03, 1, 0, 0);
      check_state("par_ok");
      pop_one("par_ok");
      send_frame(8'h03, 1, 1, 0);
      check_state("par_bad");
      clear_err();
    end

    for (int n = 0; n < 40; n++) begin
      baud_div_i = 32'($urandom_range(3, 24));
      send_frame(8'($urandom), $urandom_range(0, 9) != 0, ParEn && ($urandom_range(0, 7) == 0), 0);
      check_state("rnd");
      repeat ($urandom_range(0, 3)) pop_one("rnd");
      if ($urandom_range(0, 5) == 0) clear_err();
    end
    check_state("final");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
